// File: rtl/rand_pulse_sched_pkg.sv
// Shared types and helpers for the random pulse scheduler.
// Holds the LFSR polynomial, FSM state type and range-mask helper.
package rand_pulse_sched_pkg;

  localparam logic [15:0] c_lfsr_poly = 16'hB400;

  typedef enum logic [1:0] {
    S_IDLE,
    S_PULSE,
    S_GAP,
    S_FINISH
  } t_sched_state;

  // Smallest 2^k-1 that is >= range (bit smear).
  function automatic logic [15:0] f_range_mask(
    input logic [15:0] range
  );
    logic [15:0] m;
    m = range;
    m = m | (m >> 1);
    m = m | (m >> 2);
    m = m | (m >> 4);
    m = m | (m >> 8);
    return m;
  endfunction

endpackage

// File: rtl/rand_pulse_sched_if.sv
// Config/status bundle between test-control regs and the scheduler.
// master: drives enable/spacing/width/mask/limit; slave: drives pulses/status.
interface rand_pulse_sched_if #(
  parameter int g_num_outputs = 4
);

  logic                     enable_i;
  logic [15:0]              min_spacing_i;
  logic [15:0]              max_spacing_i;
  logic [7:0]               width_i;
  logic [g_num_outputs-1:0] ch_mask_i;
  logic [15:0]              count_limit_i;
  logic [g_num_outputs-1:0] pulse_o;
  logic                     busy_o;
  logic                     done_o;
  logic [15:0]              pulse_count_o;

  modport master (
    output enable_i,
    output min_spacing_i,
    output max_spacing_i,
    output width_i,
    output ch_mask_i,
    output count_limit_i,
    input  pulse_o,
    input  busy_o,
    input  done_o,
    input  pulse_count_o
  );

  modport slave (
    input  enable_i,
    input  min_spacing_i,
    input  max_spacing_i,
    input  width_i,
    input  ch_mask_i,
    input  count_limit_i,
    output pulse_o,
    output busy_o,
    output done_o,
    output pulse_count_o
  );

endinterface

// File: rtl/rand_pulse_lfsr.sv
// 16-bit Galois LFSR, steps when advance_i is high.
// Ports: clk_sys_i, rst_n_i (async low), advance_i, value_o[15:0].
module rand_pulse_lfsr
  import rand_pulse_sched_pkg::*;
#(
  parameter logic [15:0] g_seed = 16'hACE1
) (
  input  logic        clk_sys_i,
  input  logic        rst_n_i,
  input  logic        advance_i,
  output logic [15:0] value_o
);

  // An all-zero state would lock up the register.
  localparam logic [15:0] c_seed =
    (g_seed == 16'h0000) ? 16'h0001 : g_seed;

  always_ff @(posedge clk_sys_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      value_o <= c_seed;
    end else if (advance_i) begin
      value_o <= {1'b0, value_o[15:1]}
               ^ (value_o[0] ? c_lfsr_poly : 16'h0000);
    end
  end

endmodule

// File: rtl/rand_pulse_sched.sv
// Pseudo-random pulse-train scheduler for delay-channel self-test.
// Ports: clk_sys_i, rst_n_i (async low), bus (slave: config in, pulses/status out).
module rand_pulse_sched
  import rand_pulse_sched_pkg::*;
#(
  parameter int          g_num_outputs = 4,
  parameter logic [15:0] g_lfsr_seed   = 16'hACE1
) (
  input  logic               clk_sys_i,
  input  logic               rst_n_i,
  rand_pulse_sched_if.slave  bus
);

  localparam int N  = g_num_outputs;
  localparam int PW = (N > 1) ? $clog2(N) : 1;
  localparam logic [N-1:0]  c_one   = 1;
  localparam logic [PW-1:0] c_ptr0  = PW'(N - 1);

  t_sched_state  state_q;
  t_sched_state  state_d;
  logic          en_q;
  logic [PW-1:0] ptr_q;
  logic [7:0]    wcnt_q;
  logic [15:0]   pcnt_q;
  logic [15:0]   limit_q;
  logic [15:0]   count_q;
  logic [N-1:0]  pulse_q;
  logic          busy_q;
  logic          done_q;
  logic [15:0]   lfsr;

  logic          start;
  logic          can_start;
  logic          lim_hit;
  logic [PW-1:0] sel;
  logic [PW-1:0] sel_hi;
  logic [PW-1:0] sel_lo;
  logic          found_hi;
  logic [15:0]   rng;
  logic [15:0]   msk;
  logic [15:0]   r;
  logic [7:0]    effw;
  logic [16:0]   sp_raw;
  logic [15:0]   spacing;

  rand_pulse_lfsr #(
    .g_seed (g_lfsr_seed)
  ) u_lfsr (
    .clk_sys_i (clk_sys_i),
    .rst_n_i   (rst_n_i),
    .advance_i (state_q != S_IDLE),
    .value_o   (lfsr)
  );

  // Round-robin: first set mask bit strictly above ptr, else lowest.
  always_comb begin
    sel_hi   = '0;
    sel_lo   = '0;
    found_hi = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      if (bus.ch_mask_i[i]) begin
        if (i > int'(ptr_q)) begin
          sel_hi   = PW'(i);
          found_hi = 1'b1;
        end else begin
          sel_lo = PW'(i);
        end
      end
    end
    sel = found_hi ? sel_hi : sel_lo;
  end

  // Spacing draw: folded LFSR sample inside [min,max], clamped
  // so the next rising edge always follows the falling edge.
  always_comb begin
    rng = (bus.max_spacing_i >= bus.min_spacing_i)
        ? bus.max_spacing_i - bus.min_spacing_i : 16'h0000;
    msk = f_range_mask(rng);
    r   = lfsr & msk;
    if (r > rng) begin
      r = r - rng - 16'd1;
    end
    effw   = (bus.width_i == 8'd0) ? 8'd1 : bus.width_i;
    sp_raw = {1'b0, bus.min_spacing_i} + {1'b0, r};
    if (sp_raw < ({9'd0, effw} + 17'd1)) begin
      sp_raw = {9'd0, effw} + 17'd1;
    end
    spacing = (sp_raw > 17'h0FFFF) ? 16'hFFFF : sp_raw[15:0];
  end

  always_comb begin
    state_d   = state_q;
    start     = 1'b0;
    can_start = en_q && (|bus.ch_mask_i);
    lim_hit   = (limit_q != 16'd0) && (count_q >= limit_q);
    unique case (state_q)
      S_IDLE: begin
        if (can_start) begin
          state_d = S_PULSE;
          start   = 1'b1;
        end
      end
      S_PULSE: begin
        if (wcnt_q == 8'd0) begin
          state_d = en_q ? S_GAP : S_IDLE;
        end
      end
      S_GAP: begin
        if (lim_hit) begin
          state_d = S_FINISH;
        end else if (!can_start) begin
          state_d = S_IDLE;
        end else if (pcnt_q == 16'd0) begin
          state_d = S_PULSE;
          start   = 1'b1;
        end
      end
      S_FINISH: begin
        if (!en_q) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_sys_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk_sys_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      en_q    <= 1'b0;
      ptr_q   <= c_ptr0;
      wcnt_q  <= '0;
      pcnt_q  <= '0;
      limit_q <= '0;
      count_q <= '0;
      pulse_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      en_q   <= bus.enable_i;
      done_q <= (state_d == S_FINISH) && (state_q != S_FINISH);
      if (start) begin
        pulse_q <= c_one << sel;
        ptr_q   <= sel;
        wcnt_q  <= effw - 8'd1;
        pcnt_q  <= spacing - 16'd1;
        limit_q <= bus.count_limit_i;
        count_q <= (state_q == S_IDLE) ? 16'd1 : count_q + 16'd1;
        busy_q  <= 1'b1;
      end else begin
        if (pcnt_q != 16'd0) begin
          pcnt_q <= pcnt_q - 16'd1;
        end
        if (state_q == S_PULSE) begin
          if (wcnt_q == 8'd0) begin
            pulse_q <= '0;
          end else begin
            wcnt_q <= wcnt_q - 8'd1;
          end
        end
        if (state_d == S_IDLE || state_d == S_FINISH) begin
          busy_q <= 1'b0;
        end
      end
    end
  end

  assign bus.pulse_o       = pulse_q;
  assign bus.busy_o        = busy_q;
  assign bus.done_o        = done_q;
  assign bus.pulse_count_o = count_q;

endmodule

// File: doc/rand_pulse_sched.md
Name: rand_pulse_sched

Overview:
- Synthesizable scheduler that generates pseudo-random pulse trains for delay-channel self-test.
- Sequences pulse start times with an LFSR-drawn spacing inside a programmable [min,max] window, holds each pulse for a programmable width, and distributes pulses round-robin over a channel mask.
- Sits between the wishbone test-control registers and the delay channel trigger inputs; replaces simulation-only stimulus for on-board loopback tests.

Parameters:
- g_num_outputs, 4, number of trigger outputs driven.
- g_lfsr_seed, 16'hACE1, LFSR reset value; 0 is forced to 1.

Ports:
- clk_sys_i  in  1  system clock.
- rst_n_i  in  1  asynchronous active-low reset.
- enable_i  in  1  level; run while high.
- min_spacing_i  in  16  minimum rising-edge-to-rising-edge period, in clocks.
- max_spacing_i  in  16  maximum period, in clocks.
- width_i  in  8  pulse high time, in clocks.
- ch_mask_i  in  g_num_outputs  channels eligible for pulses.
- count_limit_i  in  16  pulses per run; 0 = unlimited.
- pulse_o  out  g_num_outputs  one-hot trigger pulses.
- busy_o  out  1  high from first pulse start until run ends.
- done_o  out  1  one-cycle strobe when count_limit_i reached.
- pulse_count_o  out  16  pulses issued in current run.

Behaviour:
- Reset (async, rst_n_i=0): pulse_o=0, busy_o=0, done_o=0, pulse_count_o=0, FSM=IDLE, LFSR=seed, RR pointer=g_num_outputs-1.
- LFSR: 16-bit Galois, polynomial x^16+x^14+x^13+x^11+1 (mask 16'hB400), advances every clock while FSM≠IDLE.
- FSM states IDLE, PULSE, GAP, FINISH.
- IDLE:
  - Go to PULSE when enable_i=1 and ch_mask_i≠0.
  - Clear pulse_count_o on this transition.
  - Enable with mask 0: stay IDLE, no output.
- Pulse start (entry to PULSE):
  - Sample width_i, min/max, mask.
  - Eff_width = max(width_i,1).
  - Select next set mask bit strictly after RR pointer (wrapping); update pointer.
  - pulse_o is registered: bit goes high the cycle after the FSM decision; first pulse_o edge is 2 cycles after enable_i rises (1 sync sample + 1 register).
  - pulse_count_o increments at the start. busy_o=1.
- Spacing draw, single cycle at start:
  - range = max-min; if max<min, range=0.
  - m = smallest 2^k-1 ≥ range.
  - r = lfsr & m; if r>range then r -= range+1.
  - spacing = min+r.
  - spacing clamped to ≥ eff_width+1.
  - 17-bit intermediate; saturate at 16'hFFFF.
- PULSE: output held exactly eff_width cycles, then GAP. Period counter loaded with spacing-1 and decremented each cycle from start.
- GAP:
  - When counter reaches 0 and enable_i=1 and limit not reached: next pulse start, giving period exactly = spacing.
  - Limit reached: FINISH.
  - enable_i=0: IDLE, busy_o=0.
- Disable mid-PULSE: pulse completes full width (no runt), then IDLE immediately after the falling edge.
- FINISH:
  - done_o=1 for one cycle, busy_o=0.
  - Wait for enable_i=0, then IDLE; this prevents auto-restart.
- Config changes take effect only at the next pulse start.
- pulse_o is never more than one-hot. Pulses on different channels are never adjacent with zero gap (spacing > width is guaranteed).

Decomposition:
- Package rand_pulse_sched_pkg:
  - c_lfsr_poly.
  - t_sched_state enum.
  - function f_range_mask(range) returning m.
- Sub-module rand_pulse_lfsr:
  - Ports clk_sys_i, rst_n_i, advance_i, value_o[15:0].
  - Parameter g_seed.
- Spacing draw and round-robin select stay inline.

Test Plan:
- min=max=10, width=3, mask=4'b0001, limit=5:
  - 5 pulses on bit0, each 3 cycles high, rising edges exactly 10 cycles apart.
  - done_o strobes once; pulse_count_o=5.
- mask=4'b1011, min=max=8, width=2, limit=6: channel sequence 0,1,3,0,1,3.
- min=20, max=35, width=5, limit=0, run 2000 pulses:
  - Every period lies in [20,35].
  - Every value 20..35 is observed.
  - Sequence matches a reference model seeded 16'hACE1.
- width=10, min=max=6: period clamped to 11 cycles.
- min=max=50, width=8; drop enable_i on cycle 3 of a pulse: pulse stays high all 8 cycles, then IDLE, busy_o=0, no further pulses.
- Assert rst_n_i mid-PULSE: pulse_o=0 in the same cycle (async). After release with enable high, restart from pulse_count_o=1 on channel 0.
